pp_sched: RTL
=============

# pp_sched

Round-robin scheduler that shares one pp compute datapath (cmd/in1/in2 → out/out1) among NUM_REQ requesters. It accepts one command at a time through a valid/ready handshake and issues it to the datapath as a single-cycle start pulse. It waits for the datapath's done strobe and returns the result, tagged with the requester id, through a valid/ready response port. It sits between the host-side command queues and the single shared pp unit.

## Interface
- NUM_REQ, 4, number of requesters; must be ≥2.
- TIMEOUT, 255, maximum WAIT cycles before abort. Used only with PP_SCHED_TIMEOUT_EN.
- CMD_W, 2**CMD_SIZE_LOG2, command width from pp_constants.svh.
- IDW, $clog2(NUM_REQ), requester id width.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester command valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- req_cmd  in  NUM_REQ*CMD_W  requester i at [i*CMD_W +: CMD_W].
- req_in1, req_in2  in  NUM_REQ*NUM_SIZE  operands; requester i at [i*NUM_SIZE +: NUM_SIZE].
- dp_start  out  1  one-cycle issue strobe to the datapath.
- dp_cmd  out  CMD_W  latched command.
- dp_in1, dp_in2  out  NUM_SIZE  latched operands; held stable from accept until the next accept.
- dp_done  in  1  datapath result strobe.
- dp_out  in  1  datapath flag result.
- dp_out1  in  NUM_SIZE  datapath numeric result.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response accept.
- resp_id  out  IDW  index of the requester that owns the response.
- resp_out  out  1  latched dp_out.
- resp_out1  out  NUM_SIZE  latched dp_out1.
- resp_err  out  1  timeout abort flag.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE → ISSUE → WAIT → RESP → IDLE.
- IDLE: grant goes to the first i with req_valid[i] high, searching from last_grant+1 upward with wrap-around. req_ready is combinational: it is the one-hot grant, gated by state==IDLE.
- Accept: req_valid[g] && req_ready[g] at a rising edge. On accept: latch cmd/in1/in2 into the dp_* registers, set id←g, last_grant←g, go to ISSUE.
- ISSUE: dp_start=1 for exactly one cycle, then go to WAIT.
- WAIT: on dp_done, latch dp_out→resp_out and dp_out1→resp_out1, resp_err←0, go to RESP. dp_done is ignored in every state except WAIT.
- RESP: resp_valid=1. resp_id, resp_out, resp_out1 and resp_err are held stable until resp_ready. On handshake, go to IDLE. req_ready stays 0 throughout RESP; there is no overlap with a new accept.
- Requesters that deassert req_valid before being granted are skipped. The scheduler never grants an invalid requester.

## Timing
- Reset values: every output is 0, state=IDLE, last_grant=NUM_REQ-1, so requester 0 wins the first arbitration. The timeout counter resets to 0.
- Accept at edge N. dp_start is high during cycle N→N+1. The earliest sampled dp_done is at edge N+2. resp_valid rises the cycle after dp_done is sampled.
- Minimum issue interval is 4 cycles per command: accept, issue, wait 1, resp 1 with resp_ready already high.
- Simultaneous requests: strict round-robin. Each requester waits at most NUM_REQ-1 grants.
- Reset asserted mid-operation: the in-flight op is abandoned and no response is produced. dp_start and resp_valid drop immediately (asynchronous).

## Configuration
- PP_SCHED_TIMEOUT_EN defined: a counter is cleared on entering WAIT and increments each WAIT cycle without dp_done. On reaching TIMEOUT, go to RESP with resp_err=1, resp_out=0, resp_out1=0. A dp_done arriving later is ignored because the scheduler is no longer in WAIT.
- PP_SCHED_TIMEOUT_EN undefined: WAIT holds indefinitely, resp_err is tied 0, no counter logic is built, and TIMEOUT is unused.

## Test plan
- Reset then single request: req_valid=0001, cmd=2, in1=5, in2=3, dp_done 3 cycles after dp_start with out1=8, out=1 → one dp_start pulse, resp_valid with resp_id=0, resp_out1=8, resp_out=1.
- All four valid continuously, resp_ready=1 → grants in order 0,1,2,3,0. Each op spans ≥4 cycles. req_ready is never multi-hot.
- Response backpressure: resp_ready=0 for 10 cycles → resp_* stable, req_ready=0 throughout. Release → IDLE next cycle.
- Spurious dp_done in IDLE and in RESP → no state change, no response.
- Reset pulse while in WAIT → all outputs 0 and IDLE. The next request goes to requester 0 first.
- With PP_SCHED_TIMEOUT_EN and TIMEOUT=8, no dp_done → resp_valid after 8 WAIT cycles with resp_err=1, resp_out1=0. Without the macro → busy stays high and no response.

Source files
------------

// File: rtl/pp_sched.sv
// pp_sched: round-robin scheduler sharing one pp datapath among NUM_REQ requesters.
// Define PP_SCHED_TIMEOUT_EN to build the WAIT timeout abort (resp_err); otherwise WAIT holds forever.
module pp_sched #(
  parameter int NUM_REQ       = 4,
  parameter int TIMEOUT       = 255,
  parameter int CMD_SIZE_LOG2 = 2,
  parameter int NUM_SIZE      = 16,
  localparam int CMD_W        = 2**CMD_SIZE_LOG2,
  localparam int IDW          = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*CMD_W-1:0]    req_cmd,
  input  logic [NUM_REQ*NUM_SIZE-1:0] req_in1,
  input  logic [NUM_REQ*NUM_SIZE-1:0] req_in2,
  output logic                        dp_start,
  output logic [CMD_W-1:0]            dp_cmd,
  output logic [NUM_SIZE-1:0]         dp_in1,
  output logic [NUM_SIZE-1:0]         dp_in2,
  input  logic                        dp_done,
  input  logic                        dp_out,
  input  logic [NUM_SIZE-1:0]         dp_out1,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [IDW-1:0]              resp_id,
  output logic                        resp_out,
  output logic [NUM_SIZE-1:0]         resp_out1,
  output logic                        resp_err,
  output logic                        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              state_reg, state_next;
  logic [IDW-1:0]      last_grant_reg;
  logic [IDW-1:0]      id_reg;
  logic [IDW-1:0]      grant_id;
  logic                grant_found;
  logic                accept;
  logic                done_hit;
  logic                tmo_hit;
  logic [CMD_W-1:0]    dp_cmd_reg;
  logic [NUM_SIZE-1:0] dp_in1_reg, dp_in2_reg;
  logic                resp_out_reg;
  logic [NUM_SIZE-1:0] resp_out1_reg;
  int                  idx;

  // Round-robin search starting just after the previous winner.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant_reg) + k) % NUM_REQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_id    = idx[IDW-1:0];
      end
    end
  end

  // Ready is also gated by reset so every output reads 0 while reset is held.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
    assign req_ready[gi] = reset && (state_reg == IDLE) && grant_found && (grant_id == IDW'(gi));
  end

`ifdef PP_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt_reg;
  logic          resp_err_reg;
`else
  localparam int unused_timeout = TIMEOUT;
`endif

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    done_hit   = 1'b0;
    tmo_hit    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (grant_found) begin
          accept     = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: state_next = WAIT;
      WAIT: begin
        if (dp_done) begin
          done_hit   = 1'b1;
          state_next = RESP;
        end
`ifdef PP_SCHED_TIMEOUT_EN
        else if (tmo_cnt_reg == TW'(TIMEOUT - 1)) begin
          tmo_hit    = 1'b1;
          state_next = RESP;
        end
`endif
      end
      RESP: begin
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      last_grant_reg <= IDW'(NUM_REQ - 1);
      id_reg         <= '0;
      dp_cmd_reg     <= '0;
      dp_in1_reg     <= '0;
      dp_in2_reg     <= '0;
      resp_out_reg   <= 1'b0;
      resp_out1_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        dp_cmd_reg     <= req_cmd[int'(grant_id)*CMD_W +: CMD_W];
        dp_in1_reg     <= req_in1[int'(grant_id)*NUM_SIZE +: NUM_SIZE];
        dp_in2_reg     <= req_in2[int'(grant_id)*NUM_SIZE +: NUM_SIZE];
        id_reg         <= grant_id;
        last_grant_reg <= grant_id;
      end
      if (done_hit) begin
        resp_out_reg  <= dp_out;
        resp_out1_reg <= dp_out1;
      end else if (tmo_hit) begin
        resp_out_reg  <= 1'b0;
        resp_out1_reg <= '0;
      end
    end
  end

`ifdef PP_SCHED_TIMEOUT_EN
  // Counter restarts as WAIT is entered and counts WAIT cycles without dp_done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt_reg  <= '0;
      resp_err_reg <= 1'b0;
    end else begin
      if (state_reg == ISSUE) tmo_cnt_reg <= '0;
      else if (state_reg == WAIT && !dp_done && !tmo_hit) tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
      if (done_hit) resp_err_reg <= 1'b0;
      else if (tmo_hit) resp_err_reg <= 1'b1;
    end
  end
  assign resp_err = resp_err_reg;
`else
  assign resp_err = 1'b0;
`endif

  assign dp_start   = (state_reg == ISSUE);
  assign resp_valid = (state_reg == RESP);
  assign busy       = (state_reg != IDLE);
  assign dp_cmd     = dp_cmd_reg;
  assign dp_in1     = dp_in1_reg;
  assign dp_in2     = dp_in2_reg;
  assign resp_id    = id_reg;
  assign resp_out   = resp_out_reg;
  assign resp_out1  = resp_out1_reg;

endmodule
